// File: rtl/team_06_pkg.sv
// team_06_pkg
// Shared helpers for the team_06 volume ramper:
//   - SAT_MAX_W : widest sample path the saturating shift helper supports
//   - cnt_width : width of the ramp sample counter (never below 1 bit)
//   - sat_shl   : unsigned left shift saturated to an out_w-bit result
package team_06_pkg;

  localparam int unsigned SAT_MAX_W = 64;

  // clog2 of the ramp length, floored at one bit so a length of 1 still has a counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    if (n <= 32'd1) begin
      w = 32'd1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

  // Returns (i_val << sh) limited to out_w bits, or all ones in the low out_w bits
  // when any set bit would land at or above out_w. The overflow test looks at the
  // bits that would be pushed past the top, which gives the same answer as doing
  // the shift at full width without ever building the wide intermediate.
  function automatic logic [SAT_MAX_W-1:0] sat_shl(
    input logic [SAT_MAX_W-1:0] i_val,
    input int unsigned          sh,
    input int unsigned          out_w
  );
    logic [SAT_MAX_W-1:0] mask;
    logic [SAT_MAX_W-1:0] res;
    if (out_w >= SAT_MAX_W) begin
      mask = '1;
    end else begin
      mask = (64'd1 << out_w) - 64'd1;
    end
    if (i_val == '0) begin
      res = '0;
    end else if (sh >= out_w) begin
      res = mask;
    end else if ((i_val >> (out_w - sh)) != '0) begin
      res = mask;
    end else begin
      res = (i_val << sh) & mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/team_06_sat_shifter.sv
// team_06_sat_shifter
// Combinational power-of-two gain stage: o_result = i_sample << i_shift,
// clamped to all ones when the shifted value does not fit in OUT_W bits.
// Ports:
//   i_sample [IN_W]  unsigned input sample
//   i_shift  [VOL_W] shift amount (gain code)
//   o_result [OUT_W] scaled, saturated sample
module team_06_sat_shifter
  import team_06_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned VOL_W = 4
) (
  input  logic [IN_W-1:0]  i_sample,
  input  logic [VOL_W-1:0] i_shift,
  output logic [OUT_W-1:0] o_result
);

  // Scale and saturate through the shared package helper.
  always_comb begin
    o_result = OUT_W'(sat_shl(SAT_MAX_W'(i_sample), 32'(i_shift), OUT_W));
  end

endmodule

// File: rtl/team_06_volume_ramper.sv
// team_06_volume_ramper
// Scales an unsigned sample stream by 2^cur_volume with saturation. The applied
// gain walks one step toward the target every RAMP_SAMPLES accepted samples so
// gain changes never jump (no zipper noise or pops). Single-entry output
// register with valid/ready on both sides.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_audio_in        input sample        i_in_valid / o_in_ready  input handshake
//   i_volume          target shift        i_enable_volume          0 forces target 0
//   o_audio_out       scaled sample       o_out_valid / i_out_ready output handshake
//   o_cur_volume      gain in effect      o_ramping                gain != target
module team_06_volume_ramper
  import team_06_pkg::*;
#(
  parameter int unsigned IN_W         = 8,
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned VOL_W        = 4,
  parameter int unsigned RAMP_SAMPLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  i_audio_in,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [VOL_W-1:0] i_volume,
  input  logic             i_enable_volume,
  output logic [OUT_W-1:0] o_audio_out,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [VOL_W-1:0] o_cur_volume,
  output logic             o_ramping
);

  localparam int unsigned      CNT_W    = cnt_width(RAMP_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_SAMPLES - 32'd1);

  logic [OUT_W-1:0] r_audio_out;
  logic             r_out_valid;
  logic [VOL_W-1:0] r_cur_volume;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic [VOL_W-1:0] w_tgt;
  logic             w_at_tgt;
  logic [OUT_W-1:0] w_scaled;
  logic [VOL_W-1:0] w_cur_next;
  logic [CNT_W-1:0] w_cnt_next;

  // The shift uses the gain in effect before this cycle's ramp update.
  team_06_sat_shifter #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .VOL_W (VOL_W)
  ) u_sat_shifter (
    .i_sample (i_audio_in),
    .i_shift  (r_cur_volume),
    .o_result (w_scaled)
  );

  // Handshake, effective target and ramp status.
  always_comb begin
    o_in_ready = !r_out_valid || i_out_ready;
    w_accept   = i_in_valid && o_in_ready;
    if (i_enable_volume) begin
      w_tgt = i_volume;
    end else begin
      w_tgt = '0;
    end
    w_at_tgt  = (r_cur_volume == w_tgt);
    o_ramping = !w_at_tgt;
  end

  // Ramp step: the counter runs on accepted samples only while off target and
  // is not cleared on a target change, so a reversal keeps its place in the count.
  always_comb begin
    w_cur_next = r_cur_volume;
    w_cnt_next = r_cnt;
    if (w_at_tgt) begin
      w_cnt_next = '0;
    end else if (w_accept) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_next = '0;
        if (w_tgt > r_cur_volume) begin
          w_cur_next = r_cur_volume + VOL_W'(1);
        end else begin
          w_cur_next = r_cur_volume - VOL_W'(1);
        end
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  // Output register: load on accept, drop valid once drained with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_audio_out <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_audio_out <= w_scaled;
      r_out_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Gain and ramp counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_volume <= '0;
      r_cnt        <= '0;
    end else begin
      r_cur_volume <= w_cur_next;
      r_cnt        <= w_cnt_next;
    end
  end

  assign o_audio_out  = r_audio_out;
  assign o_out_valid  = r_out_valid;
  assign o_cur_volume = r_cur_volume;

endmodule

// File: tb/tb_team_06_volume_ramper.sv
// Self-checking bench for team_06_volume_ramper (RAMP_SAMPLES = 4).
module tb_team_06_volume_ramper;

  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int VOL_W = 4;
  localparam int RAMP  = 4;
  localparam longint OUT_MAX = (longint'(1) << OUT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  audio_in;
  logic             in_valid;
  logic             in_ready;
  logic [VOL_W-1:0] volume;
  logic             enable_volume;
  logic [OUT_W-1:0] audio_out;
  logic             out_valid;
  logic             out_ready;
  logic [VOL_W-1:0] cur_volume;
  logic             ramping;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  team_06_volume_ramper #(
    .IN_W         (IN_W),
    .OUT_W        (OUT_W),
    .VOL_W        (VOL_W),
    .RAMP_SAMPLES (RAMP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_audio_in      (audio_in),
    .i_in_valid      (in_valid),
    .o_in_ready      (in_ready),
    .i_volume        (volume),
    .i_enable_volume (enable_volume),
    .o_audio_out     (audio_out),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_cur_volume    (cur_volume),
    .o_ramping       (ramping)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int     m_cur;
  int     m_cnt;
  logic   m_ov;
  longint m_out;
  int     m_tgt;
  logic   m_acc;

  // Gain in plain arithmetic: multiply by two sh times, clamp to the output range.
  function automatic longint scale(input longint x, input int sh);
    longint p;
    p = x;
    for (int i = 0; i < sh; i++) p = p * 2;
    return (p > OUT_MAX) ? OUT_MAX : p;
  endfunction

  always_comb begin
    m_tgt = enable_volume ? int'(volume) : 0;
    m_acc = in_valid && (!m_ov || out_ready);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur <= 0;
      m_cnt <= 0;
      m_ov  <= 1'b0;
      m_out <= 0;
    end else begin
      if (m_acc) begin
        m_out <= scale(longint'(audio_in), m_cur);
        m_ov  <= 1'b1;
      end else if (out_ready) begin
        m_ov <= 1'b0;
      end
      if (m_cur == m_tgt) begin
        m_cnt <= 0;
      end else if (m_acc) begin
        if (m_cnt + 1 == RAMP) begin
          m_cnt <= 0;
          m_cur <= (m_tgt > m_cur) ? m_cur + 1 : m_cur - 1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(!m_ov || out_ready));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("cur_volume", 64'(cur_volume), 64'(m_cur));
    chk("ramping", 64'(ramping), 64'(m_cur != m_tgt));
    if (m_ov) chk("audio_out", 64'(audio_out), 64'(m_out));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    audio_in      = '0;
    in_valid      = 1'b0;
    volume        = '0;
    enable_volume = 1'b0;
    out_ready     = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_audio_out", 64'(audio_out), 64'd0);
    chk("rst_cur_volume", 64'(cur_volume), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ramping", 64'(ramping), 64'd0);
    rst = 1'b0;

    // Unity gain pass-through.
    in_valid = 1'b1;
    audio_in = 8'd64;
    repeat (5) tick();
    chk("t1_audio", 64'(audio_out), 64'd64);
    chk("t1_cur", 64'(cur_volume), 64'd0);
    chk("t1_ramping", 64'(ramping), 64'd0);

    // Ramp 0 -> 6, one step per 4 accepted samples.
    enable_volume = 1'b1;
    volume        = 4'd6;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 4) begin
        chk("t2_out4", 64'(audio_out), 64'd64);
        chk("t2_cur4", 64'(cur_volume), 64'd1);
      end
      if (k == 5) chk("t2_out5", 64'(audio_out), 64'd128);
      if (k == 23) chk("t2_ramp23", 64'(ramping), 64'd1);
    end
    chk("t2_ramp24", 64'(ramping), 64'd0);
    chk("t2_cur24", 64'(cur_volume), 64'd6);
    chk("t2_out24", 64'(audio_out), 64'd2048);
    tick();
    chk("t2_out25", 64'(audio_out), 64'd4096);

    // Saturation at full gain.
    volume   = 4'd15;
    audio_in = 8'd255;
    repeat (40) tick();
    chk("t3_cur", 64'(cur_volume), 64'd15);
    chk("t3_sat", 64'(audio_out), 64'hFFFF);
    audio_in = 8'd1;
    tick();
    chk("t3_top", 64'(audio_out), 64'h8000);

    // Mid-ramp reversal keeps the counter position.
    rst      = 1'b1;
    volume   = 4'd6;
    audio_in = 8'd64;
    tick();
    rst = 1'b0;
    repeat (14) tick();
    chk("t4_cur3", 64'(cur_volume), 64'd3);
    volume = 4'd1;
    tick();
    chk("t4_hold3", 64'(cur_volume), 64'd3);
    tick();
    chk("t4_cur2", 64'(cur_volume), 64'd2);
    repeat (3) tick();
    chk("t4_hold2", 64'(cur_volume), 64'd2);
    tick();
    chk("t4_cur1", 64'(cur_volume), 64'd1);
    chk("t4_ramp", 64'(ramping), 64'd0);
    repeat (8) tick();
    chk("t4_stay1", 64'(cur_volume), 64'd1);

    // Backpressure.
    audio_in = 8'd100;
    tick();
    chk("t5_pre", 64'(audio_out), 64'd200);
    out_ready = 1'b0;
    audio_in  = 8'd101;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_in_ready", 64'(in_ready), 64'd0);
      chk("t5_hold_out", 64'(audio_out), 64'd200);
      chk("t5_hold_cur", 64'(cur_volume), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("t5_resume1", 64'(audio_out), 64'd202);
    audio_in = 8'd102;
    tick();
    chk("t5_resume2", 64'(audio_out), 64'd204);

    // Asynchronous reset mid-ramp.
    volume = 4'd10;
    repeat (6) tick();
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    chk("t6_pre_cur", 64'(cur_volume), 64'd2);
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_audio", 64'(audio_out), 64'd0);
    chk("t6_cur", 64'(cur_volume), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    chk("t6_ramping", 64'(ramping), 64'd1);
    tick();
    tick();
    rst = 1'b0;

    // Randomized traffic against the model.
    repeat (400) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      audio_in  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) volume = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) enable_volume = ~enable_volume;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/team_06_volume_ramper.md
# team_06_volume_ramper

Parametrised successor to the team_06 volume shifter. It scales an unsigned audio sample stream by a power-of-two gain (left shift by the volume code) and saturates the result to the output width. Gain changes ramp one step at a time, spaced by a programmable number of samples, to avoid zipper noise and pops. It sits between the sample source and the PWM/DAC output stage and uses a valid/ready handshake on both sides.

## Interface
- IN_W, 8, input sample width (unsigned)
- OUT_W, 16, output sample width (unsigned); must be ≥ IN_W
- VOL_W, 4, volume code width; shift range 0 to 2^VOL_W−1
- RAMP_SAMPLES, 64, accepted samples per one-step gain change; must be ≥ 1
---
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- audio_in  in  IN_W  input sample
- in_valid  in  1  audio_in is valid
- in_ready  out  1  block accepts a sample this cycle
- volume  in  VOL_W  target shift amount
- enable_volume  in  1  1: target = volume; 0: target = 0 (unity gain)
- audio_out  out  OUT_W  scaled, saturated sample
- out_valid  out  1  audio_out is valid
- out_ready  in  1  downstream accepts audio_out
- cur_volume  out  VOL_W  gain currently applied
- ramping  out  1  cur_volume ≠ effective target

## Operation
- Accept: a sample is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. The output register is single-entry, with no skid buffer.
- Scaling: result = zero_extend(audio_in) << cur_volume, computed at full width (IN_W + 2^VOL_W − 1 bits).
  - If any bit at or above OUT_W is set, audio_out = all ones.
  - Otherwise audio_out = result[OUT_W−1:0].
- The shift uses cur_volume as it stands before any update in the accepting cycle.
- Effective target: tgt = enable_volume ? volume : 0. It is sampled combinationally every cycle.
- Ramp counter cnt (width clog2(RAMP_SAMPLES), minimum 1):
  - On each accepted sample with cur_volume ≠ tgt:
    - if cnt == RAMP_SAMPLES−1: cnt ← 0 and cur_volume steps by ±1 toward tgt;
    - otherwise cnt ← cnt+1.
  - Whenever cur_volume == tgt: cnt ← 0.
  - With no accepted sample, cur_volume and cnt hold, so the ramp advances only with samples.
- Target change mid-ramp: the direction is re-evaluated immediately and cnt is not cleared. A target crossing cur_volume reverses the step.
- Disabling volume ramps down to shift 0 (pass-through). It never snaps.
- ramping = (cur_volume ≠ tgt), combinational.

## Timing
- Reset (async, immediate):
  - audio_out = 0, out_valid = 0, cur_volume = 0, cnt = 0
  - in_ready = 1
  - ramping reflects tgt ≠ 0
- Latency: one cycle. A sample accepted at edge N is on audio_out with out_valid = 1 after edge N.
- Throughput: one sample per cycle while out_ready = 1.
- out_valid clears after a cycle with out_ready = 1 and no new accept. Simultaneous accept and drain keeps out_valid = 1 with the new data.
- Backpressure: while out_valid && !out_ready, audio_out, out_valid, cur_volume and cnt are all stable.
- Reset asserted mid-stream drops the held sample and any partial ramp.

## Structure
- team_06_pkg holds:
  - the saturating shift function sat_shl(in, sh) parametrised by widths;
  - localparam helpers for the counter width.
- Optional sub-module team_06_sat_shifter: combinational shift plus saturation, instantiated once. Everything else stays in team_06_volume_ramper.

## Test plan
1. Reset, then enable_volume = 0, feed 64 continuously → audio_out = 64 one cycle after each accept; cur_volume = 0; ramping = 0.
2. RAMP_SAMPLES = 4, enable_volume = 1, volume = 6, audio_in = 64 streamed:
   - cur_volume steps 0→1→…→6, one step per 4 accepted samples;
   - outputs 64, 128, 256, … 4096;
   - ramping drops after the 24th accept.
3. Settled at volume 15, audio_in = 255 → audio_out = 16'hFFFF (saturated). audio_in = 1 → 16'h8000.
4. Mid-ramp (cur_volume = 3, climbing to 6): set volume = 1 → the next steps go 3→2→1 with cnt not reset, then hold at 1.
5. out_ready = 0 for 5 cycles with in_valid = 1 → in_ready = 0; audio_out and cur_volume stable. Release → the stream resumes with no dropped or duplicated samples.
6. Assert rst during a ramp with out_valid = 1 → out_valid = 0, audio_out = 0, cur_volume = 0 immediately, without waiting for a clock edge.
